uart_tx_arbiter: RTL and testbench

// Shares the single UART tx serializer between NUM_REQ message sources (command-ack responder, status/telemetry reporters).

---
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART tx serializer among NUM_REQ message sources
//   clk          system clock
//   Reset_n      asynchronous active-low reset
//   req_valid    per-requester byte valid
//   req_data     byte of requester i on [8i+7:8i]
//   req_last     byte is the last of its message
//   req_ready    byte accepted when valid & ready (only the granted requester, only in LOAD)
//   tx_din       byte presented to the serializer
//   tx_send      Send request to the serializer
//   tx_sent      Sent acknowledge from the serializer
//   grant_id     index of the current or most recent grant
//   busy         arbiter is handling a message
//   timeout_err  one-cycle pulse when the watchdog aborts a message
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1 << 20
) (
    input  logic                       clk,
    input  logic                       Reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_din,
    output logic                       tx_send,
    input  logic                       tx_sent,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT_CLR} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic [7:0]      din_q, din_d;
    logic            last_q, last_d;
    logic            to_q;
    logic            expire;
    logic            found;
    logic [GW-1:0]   pick;
    logic [GW-1:0]   cand;
    logic [7:0]      sel_byte;

    // First valid requester after the last one served, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(rr_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign sel_byte = 8'(req_data >> {grant_q, 3'b000});
    assign expire   = (state_q != IDLE) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        din_d   = din_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (req_valid[grant_q]) begin
                    din_d   = sel_byte;
                    last_d  = req_last[grant_q];
                    state_d = SEND;
                end
            end
            SEND: state_d = tx_sent ? WAIT_CLR : SEND;
            WAIT_CLR: begin
                if (!tx_sent) begin
                    state_d = last_q ? IDLE : LOAD;
                    rr_d    = last_q ? grant_q : rr_q;
                end
            end
            default: state_d = IDLE;
        endcase
        // Watchdog abort overrides whatever else happened this cycle.
        if (expire) begin
            state_d = IDLE;
            rr_d    = grant_q;
            din_d   = din_q;
            last_d  = last_q;
        end
        cnt_d = (state_q == IDLE || state_d != state_q) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            rr_q    <= GW'(NUM_REQ - 1);
            din_q   <= '0;
            last_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            din_q   <= din_d;
            last_q  <= last_d;
            to_q    <= expire;
        end
    end

    assign req_ready   = (state_q == LOAD) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q) : '0;
    assign tx_din      = din_q;
    assign tx_send     = (state_q == SEND);
    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = to_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a message-level round-robin model
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0]   req_last = '0;
    logic [NR-1:0]   req_ready;
    logic [7:0]      tx_din;
    logic            tx_send;
    logic            tx_sent = 1'b0;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout_err;

    uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .Reset_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_din(tx_din), .tx_send(tx_send),
        .tx_sent(tx_sent), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    logic [8:0]    mem [NR][256];
    int            head [NR];
    int            tail [NR];
    logic [NR-1:0] stall = '0;
    logic [NR-1:0] acc = '0;
    logic          flush = 1'b0;
    logic          tx_stuck = 1'b0;
    logic          prev_send = 1'b0;
    int            tx_dly = 10;
    int            txc, cyc, to_cnt, bad_ready, bad_send;
    logic [15:0]   obs [$];
    logic [15:0]   exp_q [$];
    int            vectors, miscompares, mdl_rr, base;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        acc <= req_valid & req_ready;
    end

    // Monitor, serializer model and requester queues, all updated away from the active edge.
    always @(negedge clk) begin
        if (tx_send && !prev_send) obs.push_back({6'b0, grant_id, tx_din});
        if (timeout_err) to_cnt++;
        if (tx_send && tx_sent) bad_send++;
        if (req_ready != '0 && req_ready != (4'b0001 << grant_id)) bad_ready++;
        prev_send = tx_send;
        if (!rst_n) begin
            tx_sent = 1'b0;
            txc = 0;
        end else if (tx_send && !tx_sent) begin
            if (!tx_stuck) begin
                txc++;
                if (txc >= tx_dly) begin
                    tx_sent = 1'b1;
                    txc = 0;
                end
            end
        end else begin
            if (tx_sent && !tx_send) tx_sent = 1'b0;
            txc = 0;
        end
        for (int i = 0; i < NR; i++) begin
            if (flush) head[i] = tail[i];
            else if (acc[i]) head[i]++;
            req_valid[i] = (head[i] != tail[i]) && !stall[i];
            req_data[8*i +: 8] = mem[i][head[i] & 255][7:0];
            req_last[i] = mem[i][head[i] & 255][8];
        end
    end

    task automatic check(string tag, logic [31:0] o, logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic push_byte(int r, logic [7:0] b, logic last);
        mem[r][tail[r] & 255] = {last, b};
        tail[r]++;
    endtask

    task automatic push_msg(int r, int n);
        for (int b = 0; b < n; b++) push_byte(r, 8'($urandom), b == n - 1);
    endtask

    function automatic bit q_empty();
        for (int i = 0; i < NR; i++) if (head[i] != tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Whole messages are served in round-robin order starting after the last served requester.
    task automatic build_exp();
        int mh [NR];
        int p;
        int j;
        logic [8:0] e;
        exp_q.delete();
        for (int i = 0; i < NR; i++) mh[i] = head[i];
        p = 0;
        while (p >= 0) begin
            p = -1;
            for (int k = NR; k >= 1; k--) begin
                j = (mdl_rr + k) % NR;
                if (mh[j] != tail[j]) p = j;
            end
            if (p >= 0) begin
                do begin
                    e = mem[p][mh[p] & 255];
                    exp_q.push_back({6'b0, 2'(p), e[7:0]});
                    mh[p]++;
                end while (!e[8]);
                mdl_rr = p;
            end
        end
    endtask

    task automatic compare_run(string tag);
        bit done = 1'b0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk);
            done = (obs.size() >= base + exp_q.size()) && !busy && q_empty();
        end
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_count"}, obs.size() - base, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            if (base + k < obs.size()) check({tag, "_byte"}, obs[base + k], exp_q[k]);
        base = obs.size();
    endtask

    task automatic wait_send(string tag);
        for (int t = 0; t < 200 && !tx_send; t++) @(negedge clk);
        check({tag, "_send_seen"}, 32'(tx_send), 1);
    endtask

    initial begin
        int t0;
        mdl_rr = NR - 1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_send", 32'(tx_send), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_grant", 32'(grant_id), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_din", 32'(tx_din), 0);
        check("rst_timeout", 32'(timeout_err), 0);
        rst_n = 1'b1;

        // single message 'A','B' with a slow serializer, plus latency
        @(posedge clk); #1;
        push_byte(0, 8'h41, 1'b0);
        push_byte(0, 8'h42, 1'b1);
        build_exp();
        @(posedge clk); #1;
        check("lat_ready", 32'(req_ready), 32'b0001);
        check("lat_nosend", 32'(tx_send), 0);
        @(posedge clk); #1;
        check("lat_send", 32'(tx_send), 1);
        check("lat_din", 32'(tx_din), 32'h41);
        compare_run("t1");
        push_msg(1, 1);
        push_msg(0, 1);
        build_exp();
        compare_run("t1_rr");

        // contention from reset, then pointer moves past requester 2
        @(negedge clk); rst_n = 1'b0;
        mdl_rr = NR - 1;
        @(negedge clk); rst_n = 1'b1;
        tx_dly = 2;
        push_msg(0, 1);
        push_msg(1, 1);
        push_msg(2, 1);
        build_exp();
        compare_run("t2a");
        push_msg(0, 1);
        push_msg(3, 1);
        build_exp();
        compare_run("t2b");

        // atomicity: requester 1's three bytes precede requester 0
        tx_dly = 3;
        push_msg(1, 3);
        push_msg(0, 1);
        build_exp();
        compare_run("t3");
        check("t3_ready_onehot", bad_ready, 0);

        // serializer stall triggers the watchdog
        tx_stuck = 1'b1;
        push_msg(2, 1);
        push_msg(3, 1);
        build_exp();
        wait_send("t4");
        t0 = cyc;
        for (int t = 0; t < 100 && !timeout_err; t++) @(negedge clk);
        check("t4_pulse", 32'(timeout_err), 1);
        check("t4_delay", cyc - t0, TO);
        check("t4_send_off", 32'(tx_send), 0);
        check("t4_idle", 32'(busy), 0);
        tx_stuck = 1'b0;
        @(negedge clk);
        check("t4_pulse_len", 32'(timeout_err), 0);
        check("t4_next_grant", 32'(grant_id), 3);
        compare_run("t4");
        check("t4_to_count", to_cnt, 1);

        // reset in the middle of a message
        tx_dly = 6;
        push_msg(1, 2);
        build_exp();
        wait_send("t5");
        check("t5_grant", 32'(grant_id), 1);
        check("t5_din", 32'(tx_din), 32'(exp_q[0][7:0]));
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_send", 32'(tx_send), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_grant", 32'(grant_id), 0);
        flush = 1'b1;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b0;
        base = obs.size();
        mdl_rr = NR - 1;
        rst_n = 1'b1;
        push_msg(3, 1);
        push_msg(0, 1);
        build_exp();
        compare_run("t5");

        // granted requester drops valid for five cycles
        tx_dly = 2;
        push_msg(2, 3);
        build_exp();
        wait_send("t6");
        stall[2] = 1'b1;
        for (int t = 0; t < 100 && !req_ready[2]; t++) @(negedge clk);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("t6_hold", {25'b0, busy, grant_id, req_ready}, {25'b0, 1'b1, 2'd2, 4'b0100});
        end
        stall[2] = 1'b0;
        compare_run("t6");
        check("t6_no_timeout", to_cnt, 1);

        // randomized message sets
        for (int r = 0; r < 25; r++) begin
            tx_dly = $urandom_range(1, 6);
            for (int i = 0; i < NR; i++)
                for (int m = $urandom_range(0, 2); m > 0; m--) push_msg(i, $urandom_range(1, 4));
            if (q_empty()) push_msg($urandom_range(0, NR - 1), 1);
            build_exp();
            compare_run("rnd");
        end

        check("inv_ready", bad_ready, 0);
        check("inv_send_sent", bad_send, 0);
        check("inv_timeouts", to_cnt, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
